// File: rtl/sync_pkg.sv
// Shared helpers for the write-to-read pointer synchronizer family.
// Widths are padded to MAX_PW so one function serves every pointer size.
package sync_pkg;

    localparam int MIN_STAGES = 2;
    localparam int MAX_STAGES = 4;
    localparam int MAX_PW     = 32;

    // Zero-padded upper bits leave the XOR prefix of the real bits untouched.
    function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] g);
        logic [MAX_PW-1:0] b;
        b[MAX_PW-1] = g[MAX_PW-1];
        for (int i = MAX_PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit leaves something.
    function automatic logic popcnt_gt1(input logic [MAX_PW-1:0] x);
        return (x & (x - MAX_PW'(1))) != '0;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain N-flop resettable shift chain used as a clock-domain synchronizer.
// No logic sits between stages so every flop can resolve metastability.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: this array is a bank of flops, not a RAM, so each stage is reset like any register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sync_w2r_mc.sv
// Multi-channel Gray write-pointer synchronizer for the read domain: brings each
// pointer across, decodes it to binary, pulses on advances and flags illegal jumps.
module sync_w2r_mc
    import sync_pkg::*;
#(
    parameter int  ADDRSIZE    = 4,
    parameter int  CHANNELS    = 1,
    parameter int  SYNC_STAGES = 2,
    localparam int PW          = ADDRSIZE + 1
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic [CHANNELS*PW-1:0] wptr,
    input  logic [CHANNELS-1:0]    clr_err,
    output logic [CHANNELS*PW-1:0] rq_wptr,
    output logic [CHANNELS*PW-1:0] rq_wbin,
    output logic [CHANNELS-1:0]    rq_wadv,
    output logic [CHANNELS*PW-1:0] rq_wdelta,
    output logic [CHANNELS-1:0]    gray_err
);

    if (SYNC_STAGES < MIN_STAGES || SYNC_STAGES > MAX_STAGES) begin : g_bad_stages
        $error("sync_w2r_mc: SYNC_STAGES must lie between 2 and 4");
    end
    if (CHANNELS < 1 || PW > MAX_PW) begin : g_bad_shape
        $error("sync_w2r_mc: CHANNELS must be >= 1 and PW at most 32");
    end

    localparam int FW = $clog2(SYNC_STAGES + 1);

    logic [PW-1:0]       sync_g  [CHANNELS];
    logic [PW-1:0]       prev_q  [CHANNELS];
    logic [PW-1:0]       bin_q   [CHANNELS];
    logic [PW-1:0]       bin_d   [CHANNELS];
    logic [PW-1:0]       delta_q [CHANNELS];
    logic [PW-1:0]       delta_d [CHANNELS];
    logic [CHANNELS-1:0] adv_q, adv_d;
    logic [CHANNELS-1:0] err_q, err_d;
    logic [CHANNELS-1:0] first_n_q, first_n_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic                fill_full;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        sync_chain #(
            .WIDTH (PW),
            .STAGES(SYNC_STAGES)
        ) u_chain (
            .clk_i (rclk),
            .rst_ni(rrst_n),
            .d_i   (wptr[c*PW +: PW]),
            .q_o   (sync_g[c])
        );

        assign rq_wptr[c*PW +: PW]   = sync_g[c];
        assign rq_wbin[c*PW +: PW]   = bin_q[c];
        assign rq_wdelta[c*PW +: PW] = delta_q[c];
    end

    assign rq_wadv  = adv_q;
    assign gray_err = err_q;

    // Chain contents are reset zeros until SYNC_STAGES edges have passed; the first
    // real sample is decoded one edge later, and that 0->value step is never checked.
    assign fill_full = (fill_q == FW'(SYNC_STAGES));
    assign fill_d    = fill_full ? fill_q : fill_q + FW'(1);

    // NOTE: every _d signal is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            bin_d[c]     = PW'(gray2bin(MAX_PW'(sync_g[c])));
            adv_d[c]     = (sync_g[c] != prev_q[c]);
            delta_d[c]   = adv_d[c] ? bin_d[c] - bin_q[c] : '0;
            err_d[c]     = (err_q[c] & ~clr_err[c])
                         | (first_n_q[c] & popcnt_gt1(MAX_PW'(sync_g[c] ^ prev_q[c])));
            first_n_d[c] = first_n_q[c] | fill_full;
        end
    end

    // NOTE: registers take their next state with non-blocking <= so every flop sees pre-edge values.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                prev_q[c]  <= '0;
                bin_q[c]   <= '0;
                delta_q[c] <= '0;
            end
            adv_q     <= '0;
            err_q     <= '0;
            first_n_q <= '0;
            fill_q    <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                prev_q[c]  <= sync_g[c];
                bin_q[c]   <= bin_d[c];
                delta_q[c] <= delta_d[c];
            end
            adv_q     <= adv_d;
            err_q     <= err_d;
            first_n_q <= first_n_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: tb/tb_sync_w2r_mc.sv
// Self-checking bench: directed vector table, Gray-count wrap, channel isolation,
// mid-stream reset and randomized traffic against a sample-history reference model.
module tb_sync_w2r_mc;

    localparam int SA = 2;
    localparam int SB = 3;

    logic        rclk   = 1'b0;
    logic        rrst_n = 1'b0;

    logic [4:0]  wa   = '0;
    logic        clra = 1'b0;
    logic [4:0]  g_a, b_a, d_a;
    logic        adv_a, err_a;

    logic [14:0] wb   = '0;
    logic [2:0]  clrb = '0;
    logic [14:0] g_b, b_b, d_b;
    logic [2:0]  adv_b, err_b;

    int checks = 0;
    int errors = 0;

    // Reference model state: every wptr value seen at each edge since reset.
    logic [4:0]  qa [$];
    logic [14:0] qb [$];
    logic        m_err_a;
    logic [2:0]  m_err_b;

    int cnt_a;
    int cnt_b [3];

    sync_w2r_mc #(.ADDRSIZE(4), .CHANNELS(1), .SYNC_STAGES(SA)) dut_a (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .wptr     (wa),
        .clr_err  (clra),
        .rq_wptr  (g_a),
        .rq_wbin  (b_a),
        .rq_wadv  (adv_a),
        .rq_wdelta(d_a),
        .gray_err (err_a)
    );

    sync_w2r_mc #(.ADDRSIZE(4), .CHANNELS(3), .SYNC_STAGES(SB)) dut_b (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .wptr     (wb),
        .clr_err  (clrb),
        .rq_wptr  (g_b),
        .rq_wbin  (b_b),
        .rq_wadv  (adv_b),
        .rq_wdelta(d_b),
        .gray_err (err_b)
    );

    always #5 rclk = ~rclk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [4:0] gray(input int x);
        int v;
        v = x % 32;
        return 5'(v ^ (v >> 1));
    endfunction

    // Binary value whose Gray code is g, found by search rather than by XOR folding.
    function automatic logic [4:0] g2b(input logic [4:0] g);
        for (int b = 0; b < 32; b++) begin
            if ((b ^ (b >> 1)) == int'(g)) return 5'(b);
        end
        return 5'd0;
    endfunction

    function automatic logic [4:0] sa(input int k);
        return (k < 1) ? 5'd0 : qa[k-1];
    endfunction

    function automatic logic [4:0] sb(input int k, input int c);
        logic [14:0] v;
        if (k < 1) return 5'd0;
        v = qb[k-1];
        return v[c*5 +: 5];
    endfunction

    // After edge n the decode stage holds sample n-S against its predecessor n-S-1;
    // the first real sample (index 1) is exempt from the Gray check.
    task automatic model_edge();
        int n;
        logic [4:0] cur, prv;
        logic bad;
        qa.push_back(wa);
        qb.push_back(wb);
        n   = qa.size();
        cur = sa(n - SA);
        prv = sa(n - SA - 1);
        bad = (n - SA >= 2) && ($countones(cur ^ prv) > 1);
        m_err_a = (m_err_a & ~clra) | bad;
        for (int c = 0; c < 3; c++) begin
            cur = sb(n - SB, c);
            prv = sb(n - SB - 1, c);
            bad = (n - SB >= 2) && ($countones(cur ^ prv) > 1);
            m_err_b[c] = (m_err_b[c] & ~clrb[c]) | bad;
        end
    endtask

    task automatic compare_model();
        int n;
        logic [4:0] cur, prv, ed;
        n   = qa.size();
        cur = sa(n - SA);
        prv = sa(n - SA - 1);
        ed  = (cur != prv) ? 5'(g2b(cur) - g2b(prv)) : 5'd0;
        check("a_rq_wptr",   g_a,   sa(n - SA + 1));
        check("a_rq_wbin",   b_a,   g2b(cur));
        check("a_rq_wadv",   adv_a, cur != prv);
        check("a_rq_wdelta", d_a,   ed);
        check("a_gray_err",  err_a, m_err_a);
        for (int c = 0; c < 3; c++) begin
            cur = sb(n - SB, c);
            prv = sb(n - SB - 1, c);
            ed  = (cur != prv) ? 5'(g2b(cur) - g2b(prv)) : 5'd0;
            check($sformatf("b%0d_rq_wptr", c),   g_b[c*5 +: 5], sb(n - SB + 1, c));
            check($sformatf("b%0d_rq_wbin", c),   b_b[c*5 +: 5], g2b(cur));
            check($sformatf("b%0d_rq_wadv", c),   adv_b[c],      cur != prv);
            check($sformatf("b%0d_rq_wdelta", c), d_b[c*5 +: 5], ed);
            check($sformatf("b%0d_gray_err", c),  err_b[c],      m_err_b[c]);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        model_edge();
        #1;
    endtask

    // Reset is asserted and released between edges; optionally verifies the
    // asynchronous drop of every output before any clock edge arrives.
    task automatic do_reset(input bit chk);
        rrst_n = 1'b0;
        #1;
        if (chk) begin
            check("rst_a_outputs", {g_a, b_a, d_a, adv_a, err_a}, '0);
            check("rst_b_wptr",    g_b,   '0);
            check("rst_b_wbin",    b_b,   '0);
            check("rst_b_wdelta",  d_b,   '0);
            check("rst_b_adv_err", {adv_b, err_b}, '0);
        end
        qa.delete();
        qb.delete();
        m_err_a = 1'b0;
        m_err_b = '0;
        @(posedge rclk);
        #2 rrst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        logic [4:0] w;
        logic       clr;
        logic [4:0] g;
        logic [4:0] b;
        logic       adv;
        logic [4:0] d;
        logic       err;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // rst, wptr, clr | rq_wptr, rq_wbin, adv, delta, err (dut_a, two stages)
        tbl[0]  = '{1'b1, 5'd22, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0};
        tbl[1]  = '{1'b0, 5'd22, 1'b0, 5'd22, 5'd0,  1'b0, 5'd0,  1'b0};
        tbl[2]  = '{1'b0, 5'd22, 1'b0, 5'd22, 5'd27, 1'b1, 5'd27, 1'b0};
        tbl[3]  = '{1'b0, 5'd22, 1'b0, 5'd22, 5'd27, 1'b0, 5'd0,  1'b0};
        tbl[4]  = '{1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0};
        tbl[5]  = '{1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0};
        tbl[6]  = '{1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0};
        tbl[7]  = '{1'b0, 5'd3,  1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0};
        tbl[8]  = '{1'b0, 5'd3,  1'b0, 5'd3,  5'd0,  1'b0, 5'd0,  1'b0};
        tbl[9]  = '{1'b0, 5'd3,  1'b0, 5'd3,  5'd2,  1'b1, 5'd2,  1'b1};
        tbl[10] = '{1'b0, 5'd3,  1'b0, 5'd3,  5'd2,  1'b0, 5'd0,  1'b1};
        tbl[11] = '{1'b0, 5'd3,  1'b0, 5'd3,  5'd2,  1'b0, 5'd0,  1'b1};
        tbl[12] = '{1'b0, 5'd0,  1'b0, 5'd3,  5'd2,  1'b0, 5'd0,  1'b1};
        tbl[13] = '{1'b0, 5'd0,  1'b0, 5'd0,  5'd2,  1'b0, 5'd0,  1'b1};
        tbl[14] = '{1'b0, 5'd0,  1'b1, 5'd0,  5'd0,  1'b1, 5'd30, 1'b1};
        tbl[15] = '{1'b0, 5'd0,  1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0};
        tbl[16] = '{1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0};

        m_err_a = 1'b0;
        m_err_b = '0;
        #3;

        // Directed vectors: first sample after reset, 2-bit jump, sticky error and clear.
        for (int i = 0; i < 17; i++) begin
            wa   = tbl[i].w;
            clra = tbl[i].clr;
            if (tbl[i].rst) do_reset(1'b0);
            step();
            check($sformatf("tbl%0d_rq_wptr", i),   g_a,   tbl[i].g);
            check($sformatf("tbl%0d_rq_wbin", i),   b_a,   tbl[i].b);
            check($sformatf("tbl%0d_rq_wadv", i),   adv_a, tbl[i].adv);
            check($sformatf("tbl%0d_rq_wdelta", i), d_a,   tbl[i].d);
            check($sformatf("tbl%0d_gray_err", i),  err_a, tbl[i].err);
        end

        // Gray count through the 31->0 wrap: one pulse of delta 1 per cycle.
        wa   = '0;
        clra = 1'b0;
        wb   = '0;
        do_reset(1'b0);
        for (int i = 1; i <= 40; i++) begin
            wa = gray(i);
            step();
            compare_model();
            if (i >= SA + 1) begin
                check($sformatf("cnt%0d_adv", i),   adv_a, 1'b1);
                check($sformatf("cnt%0d_delta", i), d_a,   5'd1);
                check($sformatf("cnt%0d_err", i),   err_a, 1'b0);
            end
        end

        // Channel isolation on the three-channel, three-stage instance.
        wa = '0;
        wb = '0;
        do_reset(1'b0);
        repeat (4) step();
        wb = 15'd32;
        step();
        check("iso_k0_adv",  adv_b, 3'b000);
        check("iso_k0_wptr", g_b,   15'd0);
        step();
        check("iso_k1_adv",  adv_b, 3'b000);
        check("iso_k1_wptr", g_b,   15'd0);
        step();
        check("iso_k2_wptr", g_b,   15'd32);
        check("iso_k2_adv",  adv_b, 3'b000);
        step();
        check("iso_k3_adv",   adv_b, 3'b010);
        check("iso_k3_delta", d_b,   15'd32);
        check("iso_k3_wbin",  b_b,   15'd32);
        check("iso_k3_err",   err_b, 3'b000);
        step();
        check("iso_k4_adv",   adv_b, 3'b000);
        check("iso_k4_delta", d_b,   15'd0);

        // Randomized traffic with a reset dropped in mid-stream.
        cnt_a = 0;
        for (int c = 0; c < 3; c++) cnt_b[c] = 0;
        wa = '0;
        wb = '0;
        do_reset(1'b1);
        for (int it = 0; it < 300; it++) begin
            if (it == 150) begin
                cnt_a = 27;
                wa    = gray(cnt_a);
                clra  = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    cnt_b[c] = int'($urandom_range(0, 31));
                    wb[c*5 +: 5] = gray(cnt_b[c]);
                end
                clrb = '0;
                do_reset(1'b1);
            end else begin
                int r;
                r = int'($urandom_range(0, 19));
                if (r < 12)      cnt_a = (cnt_a + 1) % 32;
                else if (r > 17) cnt_a = int'($urandom_range(0, 31));
                wa   = gray(cnt_a);
                clra = ($urandom_range(0, 7) == 0);
                for (int c = 0; c < 3; c++) begin
                    r = int'($urandom_range(0, 19));
                    if (r < 12)      cnt_b[c] = (cnt_b[c] + 1) % 32;
                    else if (r > 18) cnt_b[c] = int'($urandom_range(0, 31));
                    wb[c*5 +: 5] = gray(cnt_b[c]);
                    clrb[c] = ($urandom_range(0, 7) == 0);
                end
            end
            step();
            compare_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_w2r_mc.md
# sync_w2r_mc

Parametrised multi-channel write-to-read pointer synchronizer. Each channel carries a Gray-coded write pointer into the read clock domain through a configurable flip-flop chain. Each channel then decodes the pointer to binary, flags advances and reports the modular advance amount. It also detects illegal multi-bit Gray jumps. It sits in the read domain of the async FIFO family, feeding rptr_empty logic for one or more FIFOs that share a read clock.

## Interface
- ADDRSIZE, 4: FIFO address bits; pointer width PW = ADDRSIZE+1.
- CHANNELS, 1: number of independent pointers synchronized (≥1).
- SYNC_STAGES, 2: flip-flops per synchronizer chain (legal 2..4; elaboration error otherwise).

Ports:
- rclk  in  1  read-domain clock; only clock in the block.
- rrst_n  in  1  asynchronous, active-low reset; all state cleared on assertion.
- wptr  in  CHANNELS*PW  Gray write pointers from the write domain, channel c at bits [c*PW +: PW]. Asynchronous to rclk.
- clr_err  in  CHANNELS  synchronous per-channel clear of gray_err.
- rq_wptr  out  CHANNELS*PW  synchronized Gray pointer (last chain stage).
- rq_wbin  out  CHANNELS*PW  registered binary decode of rq_wptr.
- rq_wadv  out  CHANNELS  one-cycle pulse: rq_wbin changed this cycle.
- rq_wdelta  out  CHANNELS*PW  (new − old) mod 2^PW of rq_wbin, valid while rq_wadv=1, else 0.
- gray_err  out  CHANNELS  sticky: consecutive rq_wptr samples differed in more than one bit.

## Operation
- Chain: per channel, stage0 <= wptr[c], stage i <= stage i−1; rq_wptr = stage SYNC_STAGES−1. No logic between stages.
- Decode stage registers, every rclk:
  - rq_wbin <= gray2bin(rq_wptr).
  - prev_g <= rq_wptr.
  - rq_wadv <= (rq_wptr != prev_g).
  - rq_wdelta <= rq_wadv_next ? gray2bin(rq_wptr) − rq_wbin : 0, truncated to PW bits (wrap-around 11111→00000 gives delta 1).
- Gray check: if popcount(rq_wptr ^ prev_g) > 1 then gray_err[c] <= 1. The decode path still updates normally; rq_wdelta then reports the apparent jump.
- clr_err[c]=1 clears gray_err[c] next edge; a same-cycle new error wins (stays 1).
- Channels are fully independent. No cross-channel ordering is guaranteed.

## Timing
- Reset values: every chain stage, prev_g, rq_wptr, rq_wbin, rq_wdelta all 0; rq_wadv 0; gray_err 0.
- A static wptr change sampled at edge k:
  - appears on rq_wptr after edge k+SYNC_STAGES−1;
  - rq_wbin, rq_wadv and rq_wdelta update one edge later (total SYNC_STAGES edges from first capture).
- rq_wadv is high exactly one cycle per observed change. Back-to-back changes give back-to-back pulses, each with its own delta.
- Reset mid-operation: outputs drop to reset values asynchronously. After deassertion, a nonzero wptr produces one rq_wadv pulse with delta = gray2bin(wptr) and no gray_err (the 0→value step is exempt on the first post-reset sample only if a flag first_n=0; first_n sets after first decode edge).
- No combinational path from any input to any output.

## Structure
- Shared package sync_pkg holds:
  - function gray2bin(logic [PW-1:0]) via XOR prefix;
  - function popcnt_gt1;
  - localparam MIN_STAGES=2, MAX_STAGES=4.
- Sub-module sync_chain #(WIDTH, STAGES): one N-flop reset-able shift chain, instantiated once per channel in a generate loop.
- Top holds the decode/check registers and the first_n flag per channel.

## Test plan
1. Reset with wptr=5'b10110, deassert: rq_wptr=5'b10110 after 2 edges (SYNC_STAGES=2). Next edge: rq_wbin=5'b11011, rq_wadv=1, delta=27, gray_err=0.
2. Increment Gray pointer each rclk from 0 through 31 and wrap to 0: rq_wadv high every cycle, delta=1 each cycle including the 31→0 wrap, gray_err stays 0.
3. Jump wptr 5'b00000→5'b00011 (2-bit change) in steady state: gray_err=1 one edge after rq_wptr shows it. Pulse clr_err: err returns to 0. Repeat with clr_err and a new violation in the same cycle: err stays 1.
4. CHANNELS=3, SYNC_STAGES=3: change only channel 1. Only rq_wadv[1] pulses, 3 edges after capture; channels 0 and 2 are unchanged.
5. Assert rrst_n low mid-stream: all outputs 0 immediately without an rclk edge. After release, the first sample follows the scenario-1 behaviour.
6. Elaborate with SYNC_STAGES=1 and SYNC_STAGES=5: both fail elaboration.
